// File: rtl/register_file_banked_if.sv
// Register file access bundle: write port, two read ports, bank control.
// The CPU side drives through master; the register file sits on slave.
interface register_file_banked_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  write;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] load_val;
    logic [ADDR_WIDTH-1:0] read_addr_a;
    logic [DATA_WIDTH-1:0] read_val_a;
    logic [ADDR_WIDTH-1:0] read_addr_b;
    logic [DATA_WIDTH-1:0] read_val_b;
    logic                  save;
    logic                  restore;
    logic                  shadow_valid;

    modport master (
        output write, write_addr, load_val,
        output read_addr_a, read_addr_b,
        output save, restore,
        input  read_val_a, read_val_b, shadow_valid
    );

    modport slave (
        input  write, write_addr, load_val,
        input  read_addr_a, read_addr_b,
        input  save, restore,
        output read_val_a, read_val_b, shadow_valid
    );
endinterface

// File: rtl/register_file_banked.sv
// Architectural register file with a shadow bank for one-edge
// save / restore / swap on interrupt and context-switch boundaries.
module register_file_banked #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_COUNT  = 8,
    parameter int ADDR_WIDTH = 3,
    parameter bit ZERO_REG   = 1'b0,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    register_file_banked_if.slave  rf
);
    logic [DATA_WIDTH-1:0] active [REG_COUNT];
    logic [DATA_WIDTH-1:0] shadow [REG_COUNT];
    logic                  valid;

    function automatic logic writable(input logic [ADDR_WIDTH-1:0] addr);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (addr == ADDR_WIDTH'(i) && !(ZERO_REG && i == 0))
                ok = 1'b1;
        end
        return ok;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [ADDR_WIDTH-1:0] addr
    );
        logic [DATA_WIDTH-1:0] val;
        val = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (addr == ADDR_WIDTH'(i) && !(ZERO_REG && i == 0))
                val = active[i];
        end
        // Forward only the write port; bank copies land after the edge.
        if (BYPASS && rf.write && rf.write_addr == addr && writable(addr))
            val = rf.load_val;
        return val;
    endfunction

    always_comb begin
        rf.read_val_a = read_port(rf.read_addr_a);
        rf.read_val_b = read_port(rf.read_addr_b);
    end

    assign rf.shadow_valid = valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                active[i] <= '0;
                shadow[i] <= '0;
            end
            valid <= 1'b0;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (!(ZERO_REG && i == 0)) begin
                    case ({rf.save, rf.restore})
                        2'b10: shadow[i] <= active[i];
                        2'b01: active[i] <= shadow[i];
                        2'b11: begin
                            active[i] <= shadow[i];
                            shadow[i] <= active[i];
                        end
                        default: ;
                    endcase
                    // Later NBA wins: the write lands on top of restore/swap.
                    if (rf.write && rf.write_addr == ADDR_WIDTH'(i))
                        active[i] <= rf.load_val;
                end
            end
            case ({rf.save, rf.restore})
                2'b10, 2'b11: valid <= 1'b1;
                2'b01:        valid <= 1'b0;
                default:      ;
            endcase
        end
    end
endmodule

// File: doc/register_file_banked.md
Name: register_file_banked

Overview:
- Parametrised register file: REG_COUNT general-purpose registers of DATA_WIDTH bits.
- Two combinational read ports and one write port; positive-edge writes with active-high enable.
- One-cycle shadow-bank save/restore/swap for interrupt and context-switch entry and exit.
- Sits in the CPU datapath as the architectural register set, replacing discrete register instances.

Parameters:
- DATA_WIDTH, 16, bits per register.
- REG_COUNT, 8, number of registers per bank; any value >= 2.
- ADDR_WIDTH, 3, address width; must satisfy 2^ADDR_WIDTH >= REG_COUNT.
- ZERO_REG, 0, when 1, register 0 always reads 0 and ignores writes, save, restore and swap.
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports.

Ports:
- clock, in, 1, clock source; all state updates on posedge.
- reset, in, 1, synchronous active-high reset.
- write, in, 1, 1 writes load_val to write_addr at posedge.
- write_addr, in, ADDR_WIDTH, destination register.
- load_val, in, DATA_WIDTH, value to write.
- read_addr_a, in, ADDR_WIDTH, port A select.
- read_val_a, out, DATA_WIDTH, port A data.
- read_addr_b, in, ADDR_WIDTH, port B select.
- read_val_b, out, DATA_WIDTH, port B data.
- save, in, 1, copy active bank to shadow bank.
- restore, in, 1, copy shadow bank to active bank.
- shadow_valid, out, 1, 1 when the shadow bank holds a saved context.

Behaviour:
- Reset: on posedge with reset=1, all active and shadow registers clear to 0 and shadow_valid clears to 0. Reset overrides write, save and restore in the same cycle.
- Reads: combinational, zero latency. read_val_x = active[read_addr_x].
- Out-of-range reads (address >= REG_COUNT) return 0. If ZERO_REG=1, address 0 returns 0.
- Bypass (BYPASS=1): when write=1, write_addr == read_addr_x, and the address is writable (in range, not zero-reg), read_val_x = load_val in the same cycle.
- With BYPASS=0, the new value is visible from the cycle after the edge.
- Bypass never forwards restore or swap data; reads during a restore cycle show pre-edge active contents.
- Write: at posedge, if write=1 and the address is writable, active[write_addr] <= load_val. Otherwise the write is ignored silently.
- Bank operations at posedge, decoded from {save, restore}:
  - 00: none.
  - 10 (save): shadow[i] <= active[i] for all i, using pre-edge values, so a same-cycle write is not captured. shadow_valid <= 1.
  - 01 (restore): active[i] <= shadow[i] for all i. shadow_valid <= 0. Restore with shadow_valid=0 still copies (zeros after reset); this is not an error.
  - 11 (swap): active and shadow exchange atomically using pre-edge values. shadow_valid <= 1.
- Write priority: a same-cycle write is applied after restore/swap, so active[write_addr] ends as load_val. Shadow contents are never affected by the write port.
- ZERO_REG=1: register 0 is excluded from all bank operations and stays 0 in both banks.
- Operation rate: every state-changing operation completes in one edge. There is no busy state, and back-to-back operations on consecutive cycles are legal.
- Reset during any operation: the reset result wins completely; no partial copy is retained.

Test Plan:
- Reset then read: assert reset for 1 cycle with write=1, load_val=16'hFFFF, addr 3 -> all read ports return 0, shadow_valid=0.
- Write/bypass: write 16'h1234 to r5 with read_addr_a=5 in the same cycle -> read_val_a=16'h1234 before the edge (BYPASS=1). With BYPASS=0, it shows 0 until after the edge.
- Save and restore:
  - Load r1..r7 = 16'h0011..16'h0077, then pulse save -> shadow_valid=1.
  - Overwrite all registers with 16'hAAAA, then pulse restore -> r1..r7 read 16'h0011..16'h0077, shadow_valid=0.
- Swap with write:
  - Active r2=16'h0002, shadow r2=16'h0200.
  - Apply save=restore=1 with write r2=16'hBEEF -> active r2=16'hBEEF, shadow r2=16'h0002, other registers exchanged.
- Save with write: save=1 plus write r4=16'h4444 while r4=16'h0004 -> shadow r4=16'h0004, active r4=16'h4444.
- ZERO_REG=1, REG_COUNT=6:
  - Write r0=16'h1111 and r6=16'h2222 -> both reads return 0.
  - Swap -> r0 stays 0 in both banks.
